// File: rtl/serial_parity_rx.sv
// serial_parity_rx: receiving end of the XOR-parity serial link.
// Frame layout: start(0), DATA_W data bits LSB first, parity bit, stop(1).
// It deserialises each frame, checks parity with an XOR accumulator, and
// presents the word with held parity/framing error flags.
// Optional build macro SERIAL_PARITY_RX_ERR_CNT_EN adds a saturating 8-bit
// count of errored frames on port err_cnt.
module serial_parity_rx #(
   parameter int DATA_W     = 8,
   parameter bit ODD_PARITY = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic              in_bit,
   output logic              busy,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              parity_err,
`ifdef SERIAL_PARITY_RX_ERR_CNT_EN
   output logic              frame_err,
   output logic [7:0]        err_cnt
`else
   output logic              frame_err
`endif
);

   localparam int CNT_W = $clog2(DATA_W + 1);

   typedef enum logic [1:0] {IDLE, DATA, PAR, STOP} state_t;

   state_t              state, state_next;
   logic [CNT_W-1:0]    cnt, cnt_next;
   logic [DATA_W-1:0]   shift, shift_next, shifted;
   logic                acc, acc_next;
   logic                parity_calc, parity_calc_next;
   logic                out_valid_next;
   logic [DATA_W-1:0]   out_data_next;
   logic                parity_err_next;
   logic                frame_err_next;

   // LSB-first reception: each new bit enters at the MSB end and moves down,
   // so after DATA_W bits the first bit received sits in bit 0.
   generate
      if (DATA_W == 1) begin : g_shift_single
         assign shifted = in_bit;
      end else begin : g_shift_multi
         assign shifted = {in_bit, shift[DATA_W-1:1]};
      end
   endgenerate

   // busy is a pure decode of the state register, so it carries no path from in_*.
   assign busy = (state != IDLE);

   // Next-state and datapath logic; everything holds unless a valid bit arrives.
   always_comb begin
      state_next       = state;
      cnt_next         = cnt;
      shift_next       = shift;
      acc_next         = acc;
      parity_calc_next = parity_calc;
      out_valid_next   = 1'b0;
      out_data_next    = out_data;
      parity_err_next  = parity_err;
      frame_err_next   = frame_err;
      case (state)
         IDLE: begin
            // A high line while idle is just the idle level and is ignored.
            if (in_valid && !in_bit) begin
               state_next = DATA;
               cnt_next   = '0;
               // Seeding with ODD_PARITY makes a correct frame always end at 0.
               acc_next   = ODD_PARITY;
            end
         end
         DATA: begin
            if (in_valid) begin
               shift_next = shifted;
               acc_next   = acc ^ in_bit;
               cnt_next   = cnt + 1'b1;
               if (cnt == CNT_W'(DATA_W - 1)) begin
                  state_next = PAR;
               end
            end
         end
         PAR: begin
            if (in_valid) begin
               parity_calc_next = acc ^ in_bit;
               state_next       = STOP;
            end
         end
         STOP: begin
            // Errored frames are still delivered; the flags describe them.
            if (in_valid) begin
               out_data_next   = shift;
               parity_err_next = parity_calc;
               frame_err_next  = ~in_bit;
               out_valid_next  = 1'b1;
               state_next      = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Datapath and output registers; reset discards any partial frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt         <= '0;
         shift       <= '0;
         acc         <= 1'b0;
         parity_calc <= 1'b0;
         out_valid   <= 1'b0;
         out_data    <= '0;
         parity_err  <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         cnt         <= cnt_next;
         shift       <= shift_next;
         acc         <= acc_next;
         parity_calc <= parity_calc_next;
         out_valid   <= out_valid_next;
         out_data    <= out_data_next;
         parity_err  <= parity_err_next;
         frame_err   <= frame_err_next;
      end
   end

`ifdef SERIAL_PARITY_RX_ERR_CNT_EN
   logic err_hit;

   // Error event is the same condition that sets either flag on completion.
   assign err_hit = (state == STOP) && in_valid && (parity_calc || !in_bit);

   // Saturating errored-frame counter, updating alongside out_valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt <= 8'd0;
      end else if (err_hit && (err_cnt != 8'hFF)) begin
         err_cnt <= err_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_serial_parity_rx.sv
// Bench for serial_parity_rx: one even-parity and one odd-parity instance,
// each with its own stimulus lines; expected frames are queued when sent and
// matched against frames captured from out_valid pulses.
module tb_serial_parity_rx;

   localparam int W = 8;

   typedef struct packed {
      logic [W-1:0] data;
      logic         perr;
      logic         ferr;
      logic [7:0]   ecnt;
   } rec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic         ev_valid = 1'b0, ev_bit = 1'b1;
   logic         od_valid = 1'b0, od_bit = 1'b1;
   logic         ev_busy, ev_out_valid, ev_perr, ev_ferr;
   logic         od_busy, od_out_valid, od_perr, od_ferr;
   logic [W-1:0] ev_data, od_data;
   logic [7:0]   ev_ecnt, od_ecnt;

   rec_t exp_ev[$], obs_ev[$], exp_od[$], obs_od[$];
   int   ev_ecnt_m = 0, od_ecnt_m = 0;
   int   n_checks = 0, n_fail = 0;

   serial_parity_rx #(.DATA_W(W), .ODD_PARITY(1'b0)) u_even (
      .clk(clk), .rst(rst), .in_valid(ev_valid), .in_bit(ev_bit),
      .busy(ev_busy), .out_valid(ev_out_valid), .out_data(ev_data),
      .parity_err(ev_perr),
`ifdef SERIAL_PARITY_RX_ERR_CNT_EN
      .frame_err(ev_ferr), .err_cnt(ev_ecnt)
`else
      .frame_err(ev_ferr)
`endif
   );

   serial_parity_rx #(.DATA_W(W), .ODD_PARITY(1'b1)) u_odd (
      .clk(clk), .rst(rst), .in_valid(od_valid), .in_bit(od_bit),
      .busy(od_busy), .out_valid(od_out_valid), .out_data(od_data),
      .parity_err(od_perr),
`ifdef SERIAL_PARITY_RX_ERR_CNT_EN
      .frame_err(od_ferr), .err_cnt(od_ecnt)
`else
      .frame_err(od_ferr)
`endif
   );

`ifndef SERIAL_PARITY_RX_ERR_CNT_EN
   assign ev_ecnt = 8'd0;
   assign od_ecnt = 8'd0;
`endif

   // Capture every completed frame, sampled mid-cycle.
   always @(negedge clk) begin
      if (ev_out_valid === 1'b1) obs_ev.push_back({ev_data, ev_perr, ev_ferr, ev_ecnt});
      if (od_out_valid === 1'b1) obs_od.push_back({od_data, od_perr, od_ferr, od_ecnt});
   end

   // Drive one cycle of the chosen link (0 = even DUT, 1 = odd DUT).
   task automatic drive(input bit sel, input logic v, input logic b);
      if (!sel) begin ev_valid = v; ev_bit = b; end
      else begin od_valid = v; od_bit = b; end
      @(posedge clk);
      #1;
   endtask

   // Send one frame with `gap` idle cycles (random line value) before each
   // bit after the start bit, and queue what the receiver must report.
   task automatic send_frame(input bit sel, input logic [W-1:0] d, input logic p,
                             input logic stp, input int gap);
      rec_t e;
      e.data = d;
      e.perr = ((^d) ^ p) != sel;
      e.ferr = ~stp;
`ifdef SERIAL_PARITY_RX_ERR_CNT_EN
      if (!sel) begin
         if ((e.perr || e.ferr) && ev_ecnt_m < 255) ev_ecnt_m++;
         e.ecnt = 8'(ev_ecnt_m);
      end else begin
         if ((e.perr || e.ferr) && od_ecnt_m < 255) od_ecnt_m++;
         e.ecnt = 8'(od_ecnt_m);
      end
`else
      e.ecnt = 8'd0;
`endif
      if (!sel) exp_ev.push_back(e); else exp_od.push_back(e);
      drive(sel, 1'b1, 1'b0);
      for (int i = 0; i < W + 2; i++) begin
         for (int g = 0; g < gap; g++) drive(sel, 1'b0, 1'($urandom_range(1, 0)));
         if (i < W) drive(sel, 1'b1, d[i]);
         else if (i == W) drive(sel, 1'b1, p);
         else drive(sel, 1'b1, stp);
      end
      if (!sel) begin ev_valid = 1'b0; ev_bit = 1'b1; end
      else begin od_valid = 1'b0; od_bit = 1'b1; end
   endtask

   task automatic test_reset;
      rec_t o;
      #2 rst = 1'b1;
      #1;
      o = {ev_data, ev_perr, ev_ferr, ev_ecnt};
      n_checks++;
      if (o !== '0 || ev_busy !== 1'b0 || ev_out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: got out=%h busy=%b out_valid=%b, expected all 0", o, ev_busy, ev_out_valid);
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      $display("[%0t] reset released", $time);
   endtask

   // Compare all queued frames of the even DUT.
   task automatic test_basic;
      rec_t e, o;
      send_frame(1'b0, 8'hA5, 1'b0, 1'b1, 0);
      n_checks++;
      if (ev_out_valid !== 1'b1 || ev_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_latency: got out_valid=%b busy=%b, expected 1 0", ev_out_valid, ev_busy);
      end
      repeat (2) @(negedge clk);
      n_checks++;
      if (obs_ev.size() != exp_ev.size()) begin
         n_fail++;
         $display("FAIL basic_count: got %0d frames, expected %0d", obs_ev.size(), exp_ev.size());
      end
      while (exp_ev.size() > 0 && obs_ev.size() > 0) begin
         e = exp_ev.pop_front(); o = obs_ev.pop_front(); n_checks++;
         $display("[%0t] basic frame data=%h perr=%b ferr=%b ecnt=%0d", $time, o.data, o.perr, o.ferr, o.ecnt);
         if (o !== e) begin n_fail++; $display("FAIL basic_frame: got %h, expected %h", o, e); end
      end
      n_checks++;
      if (ev_out_valid !== 1'b0 || ev_data !== 8'hA5) begin
         n_fail++;
         $display("FAIL basic_hold: got out_valid=%b data=%h, expected 0 a5", ev_out_valid, ev_data);
      end
   endtask

   task automatic test_errors;
      rec_t e, o;
      send_frame(1'b0, 8'hA5, 1'b1, 1'b1, 0);
      send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 0);
      repeat (2) @(negedge clk);
      n_checks++;
      if (obs_ev.size() != exp_ev.size()) begin
         n_fail++;
         $display("FAIL errors_count: got %0d frames, expected %0d", obs_ev.size(), exp_ev.size());
      end
      while (exp_ev.size() > 0 && obs_ev.size() > 0) begin
         e = exp_ev.pop_front(); o = obs_ev.pop_front(); n_checks++;
         $display("[%0t] errors frame data=%h perr=%b ferr=%b ecnt=%0d", $time, o.data, o.perr, o.ferr, o.ecnt);
         if (o !== e) begin n_fail++; $display("FAIL errors_frame: got %h, expected %h", o, e); end
      end
   endtask

   task automatic test_gaps;
      rec_t e, o;
      send_frame(1'b0, 8'h81, 1'b0, 1'b1, 3);
      repeat (2) @(negedge clk);
      n_checks++;
      if (obs_ev.size() != 1 || exp_ev.size() != 1) begin
         n_fail++;
         $display("FAIL gaps_pulses: got %0d pulses, expected 1", obs_ev.size());
      end
      while (exp_ev.size() > 0 && obs_ev.size() > 0) begin
         e = exp_ev.pop_front(); o = obs_ev.pop_front(); n_checks++;
         $display("[%0t] gaps frame data=%h perr=%b ferr=%b ecnt=%0d", $time, o.data, o.perr, o.ferr, o.ecnt);
         if (o !== e) begin n_fail++; $display("FAIL gaps_frame: got %h, expected %h", o, e); end
      end
      exp_ev.delete(); obs_ev.delete();
   endtask

   task automatic test_back_to_back;
      rec_t e, o;
      send_frame(1'b0, 8'h0F, 1'b0, 1'b1, 0);
      send_frame(1'b0, 8'hF0, 1'b0, 1'b1, 0);
      repeat (2) @(negedge clk);
      n_checks++;
      if (obs_ev.size() != 2) begin
         n_fail++;
         $display("FAIL b2b_pulses: got %0d pulses, expected 2", obs_ev.size());
      end
      while (exp_ev.size() > 0 && obs_ev.size() > 0) begin
         e = exp_ev.pop_front(); o = obs_ev.pop_front(); n_checks++;
         $display("[%0t] b2b frame data=%h perr=%b ferr=%b ecnt=%0d", $time, o.data, o.perr, o.ferr, o.ecnt);
         if (o !== e) begin n_fail++; $display("FAIL b2b_frame: got %h, expected %h", o, e); end
      end
      exp_ev.delete(); obs_ev.delete();
   endtask

   task automatic test_reset_midframe;
      rec_t e, o;
      drive(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'(i % 2));
      ev_valid = 1'b0;
      n_checks++;
      if (ev_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL midframe_busy: got %b, expected 1", ev_busy);
      end
      rst = 1'b1;
      #1;
      o = {ev_data, ev_perr, ev_ferr, ev_ecnt};
      n_checks++;
      if (o !== '0 || ev_busy !== 1'b0 || ev_out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL midframe_reset: got out=%h busy=%b out_valid=%b, expected all 0", o, ev_busy, ev_out_valid);
      end
      ev_ecnt_m = 0; od_ecnt_m = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      send_frame(1'b0, 8'h55, 1'b0, 1'b1, 0);
      repeat (2) @(negedge clk);
      n_checks++;
      if (obs_ev.size() != 1) begin
         n_fail++;
         $display("FAIL midframe_pulses: got %0d pulses, expected 1", obs_ev.size());
      end
      while (exp_ev.size() > 0 && obs_ev.size() > 0) begin
         e = exp_ev.pop_front(); o = obs_ev.pop_front(); n_checks++;
         $display("[%0t] after-reset frame data=%h perr=%b ferr=%b ecnt=%0d", $time, o.data, o.perr, o.ferr, o.ecnt);
         if (o !== e) begin n_fail++; $display("FAIL midframe_frame: got %h, expected %h", o, e); end
      end
      exp_ev.delete(); obs_ev.delete();
   endtask

   task automatic test_odd_parity;
      rec_t e, o;
      repeat (3) drive(1'b1, 1'b1, 1'b1);
      od_valid = 1'b0;
      n_checks++;
      if (od_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL odd_idle_ones: got busy=%b, expected 0", od_busy);
      end
      send_frame(1'b1, 8'h00, 1'b1, 1'b1, 0);
      send_frame(1'b1, 8'h00, 1'b0, 1'b1, 1);
      repeat (2) @(negedge clk);
      n_checks++;
      if (obs_od.size() != 2) begin
         n_fail++;
         $display("FAIL odd_pulses: got %0d pulses, expected 2", obs_od.size());
      end
      while (exp_od.size() > 0 && obs_od.size() > 0) begin
         e = exp_od.pop_front(); o = obs_od.pop_front(); n_checks++;
         $display("[%0t] odd frame data=%h perr=%b ferr=%b ecnt=%0d", $time, o.data, o.perr, o.ferr, o.ecnt);
         if (o !== e) begin n_fail++; $display("FAIL odd_frame: got %h, expected %h", o, e); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_errors();
      test_gaps();
      test_back_to_back();
      test_reset_midframe();
      test_odd_parity();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
